// File: rtl/adxl362_reg_sequencer_if.sv
// Host request/response signals and SPI-master byte link of the ADXL362 register sequencer.
// The sequencer connects through the slave modport; the host/SPI-master side uses master.
interface adxl362_reg_sequencer_if #(
    parameter int LEN_WIDTH = 3
);
    logic                 i_Start;
    logic                 i_Rw;
    logic [7:0]           i_Addr;
    logic [LEN_WIDTH-1:0] i_Len;
    logic [7:0]           i_Wr_Data;
    logic                 o_Wr_Req;
    logic [7:0]           o_Rd_Data;
    logic                 o_Rd_Valid;
    logic                 o_Busy;
    logic                 o_Done;
    logic                 o_Err;
    logic [7:0]           o_Tx_Byte;
    logic                 o_Tx_Valid;
    logic                 i_Tx_Hold;
    logic [7:0]           i_Rx_Byte;
    logic                 i_SPI_CSLow;

    modport slave (
        input  i_Start, i_Rw, i_Addr, i_Len, i_Wr_Data, i_Tx_Hold, i_Rx_Byte, i_SPI_CSLow,
        output o_Wr_Req, o_Rd_Data, o_Rd_Valid, o_Busy, o_Done, o_Err, o_Tx_Byte, o_Tx_Valid
    );

    modport master (
        output i_Start, i_Rw, i_Addr, i_Len, i_Wr_Data, i_Tx_Hold, i_Rx_Byte, i_SPI_CSLow,
        input  o_Wr_Req, o_Rd_Data, o_Rd_Valid, o_Busy, o_Done, o_Err, o_Tx_Byte, o_Tx_Valid
    );
endinterface

// File: rtl/adxl362_reg_sequencer.sv
// ADXL362 register-access sequencer: one host request becomes one chip-select frame
// (command, address, N data bytes) on the SPI master byte interface.
module adxl362_reg_sequencer #(
    parameter int         MAX_BURST = 6,
    parameter int         LEN_WIDTH = 3,
    parameter logic [7:0] CMD_WRITE = 8'h0A,
    parameter logic [7:0] CMD_READ  = 8'h0B
) (
    input logic                    clk,
    input logic                    reset,
    adxl362_reg_sequencer_if.slave bus
);
    localparam int CW = LEN_WIDTH + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_WAIT_CS,
        S_DONE
    } state_t;

    state_t state, state_n;

    logic          hold_q, cs_q;
    logic          rw_q, rw_n;
    logic [7:0]    addr_q, addr_n;
    logic [CW-1:0] len_q, len_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic [CW-1:0] smp_q, smp_n;
    logic          abort_q, abort_n;
    logic [7:0]    tx_byte_q, tx_byte_n;
    logic [7:0]    rd_data_q, rd_data_n;
    logic          tx_valid_q, tx_valid_n;
    logic          busy_q, busy_n;
    logic          done_q, done_n;
    logic          err_q, err_n;
    logic          rd_valid_q, rd_valid_n;
    logic          wr_req_q, wr_req_n;

    logic          hold_rise, hold_fall, cs_rise;
    logic          len_ok, in_frame, last_loaded, abort_ev, smp_ev;
    logic [CW-1:0] len_in;
    logic [7:0]    data_byte;

    assign hold_rise = bus.i_Tx_Hold & ~hold_q;
    assign hold_fall = ~bus.i_Tx_Hold & hold_q;
    assign cs_rise   = bus.i_SPI_CSLow & ~cs_q;

    assign len_in      = CW'(bus.i_Len);
    assign len_ok      = (len_in != '0) && (len_in <= CW'(MAX_BURST));
    assign in_frame    = (state == S_CMD) || (state == S_ADDR) || (state == S_DATA) || (state == S_WAIT_CS);
    // cnt == len in DATA means the last byte is already in the master; only the hold fall is pending
    assign last_loaded = (state == S_DATA) && (cnt_q == len_q);
    assign abort_ev    = cs_rise && ((state == S_CMD) || (state == S_ADDR) || (state == S_DATA)) && !last_loaded;
    assign smp_ev      = in_frame && (hold_fall || cs_rise);
    assign data_byte   = rw_q ? 8'h00 : bus.i_Wr_Data;

    always_comb begin
        state_n    = state;
        rw_n       = rw_q;
        addr_n     = addr_q;
        len_n      = len_q;
        cnt_n      = cnt_q;
        smp_n      = smp_q;
        abort_n    = abort_q;
        tx_byte_n  = tx_byte_q;
        tx_valid_n = tx_valid_q;
        busy_n     = busy_q;
        rd_data_n  = rd_data_q;
        done_n     = 1'b0;
        err_n      = 1'b0;
        rd_valid_n = 1'b0;
        wr_req_n   = 1'b0;

        // Samples 0/1 answer CMD/ADDR; a CS release that aborts the frame never yields data
        if (smp_ev) begin
            smp_n = smp_q + CW'(1);
            if (rw_q && !abort_ev && (smp_q >= CW'(2)) && (smp_q <= len_q + CW'(1))) begin
                rd_valid_n = 1'b1;
                rd_data_n  = bus.i_Rx_Byte;
            end
        end

        if (abort_ev) begin
            tx_valid_n = 1'b0;
            abort_n    = 1'b1;
            state_n    = S_DONE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.i_Start) begin
                        if (len_ok) begin
                            rw_n       = bus.i_Rw;
                            addr_n     = bus.i_Addr;
                            len_n      = len_in;
                            cnt_n      = '0;
                            smp_n      = '0;
                            abort_n    = 1'b0;
                            tx_byte_n  = bus.i_Rw ? CMD_READ : CMD_WRITE;
                            tx_valid_n = 1'b1;
                            busy_n     = 1'b1;
                            state_n    = S_CMD;
                        end else begin
                            err_n = 1'b1;
                        end
                    end
                end
                S_CMD: begin
                    if (hold_rise) begin
                        tx_byte_n = addr_q;
                        state_n   = S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (hold_rise) begin
                        tx_byte_n = data_byte;
                        wr_req_n  = !rw_q;
                        cnt_n     = '0;
                        state_n   = S_DATA;
                    end
                end
                S_DATA: begin
                    if (last_loaded) begin
                        if (hold_fall || cs_rise) begin
                            tx_valid_n = 1'b0;
                            state_n    = cs_rise ? S_DONE : S_WAIT_CS;
                        end
                    end else if (hold_rise) begin
                        cnt_n = cnt_q + CW'(1);
                        if (cnt_q < len_q - CW'(1)) begin
                            tx_byte_n = data_byte;
                            wr_req_n  = !rw_q;
                        end
                    end
                end
                S_WAIT_CS: begin
                    if (cs_rise) state_n = S_DONE;
                end
                S_DONE: begin
                    done_n  = 1'b1;
                    err_n   = abort_q;
                    busy_n  = 1'b0;
                    abort_n = 1'b0;
                    state_n = S_IDLE;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            hold_q     <= 1'b0;
            cs_q       <= 1'b1;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            smp_q      <= '0;
            abort_q    <= 1'b0;
            tx_byte_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            wr_req_q   <= 1'b0;
        end else begin
            state      <= state_n;
            hold_q     <= bus.i_Tx_Hold;
            cs_q       <= bus.i_SPI_CSLow;
            rw_q       <= rw_n;
            addr_q     <= addr_n;
            len_q      <= len_n;
            cnt_q      <= cnt_n;
            smp_q      <= smp_n;
            abort_q    <= abort_n;
            tx_byte_q  <= tx_byte_n;
            tx_valid_q <= tx_valid_n;
            busy_q     <= busy_n;
            done_q     <= done_n;
            err_q      <= err_n;
            rd_valid_q <= rd_valid_n;
            rd_data_q  <= rd_data_n;
            wr_req_q   <= wr_req_n;
        end
    end

    assign bus.o_Tx_Byte  = tx_byte_q;
    assign bus.o_Tx_Valid = tx_valid_q;
    assign bus.o_Busy     = busy_q;
    assign bus.o_Done     = done_q;
    assign bus.o_Err      = err_q;
    assign bus.o_Rd_Valid = rd_valid_q;
    assign bus.o_Rd_Data  = rd_data_q;
    assign bus.o_Wr_Req   = wr_req_q;
endmodule
